mc_main_control: RTL and testbench

- Main control FSM of the multicycle CPU.
- Sequences fetch/decode/execute/memory/writeback over the shared ALU, memory port and register file.
- Drives the datapath mux selects and write strobes, plus the 2-bit ALUOp consumed by the ALU control decoder.
- Stalls on a ready-based memory handshake and traps on timeout or illegal opcodes.

---
 rtl/mc_ctrl_pkg.sv | 74 +++++++
 rtl/mc_mem_wait_timer.sv | 35 +++
 rtl/mc_main_control.sv | 215 +++++++++++++++++++++
 tb/tb_mc_main_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU main control FSM: states, opcodes and
// datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_HALT   = 4'd11,
    ST_FAULT  = 4'd12
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b010000;
  localparam logic [5:0] OP_SW   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b011000;
  localparam logic [5:0] OP_BNE  = 6'b011001;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] CLS_RTYPE = 3'b000;
  localparam logic [2:0] CLS_ITYPE = 3'b001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_IMM   = 2'b01;
  localparam logic [1:0] ALUOP_BR    = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    OPC_RTYPE   = 3'd0,
    OPC_ITYPE   = 3'd1,
    OPC_MEM     = 3'd2,
    OPC_BRANCH  = 3'd3,
    OPC_JUMP    = 3'd4,
    OPC_HALT    = 3'd5,
    OPC_ILLEGAL = 3'd6
  } op_class_e;

  function automatic op_class_e classify(input logic [5:0] op);
    op_class_e cls;
    cls = OPC_ILLEGAL;
    if (op[5:3] == CLS_RTYPE) begin
      cls = OPC_RTYPE;
    end else if (op[5:3] == CLS_ITYPE) begin
      cls = OPC_ITYPE;
    end else begin
      case (op)
        OP_LW, OP_SW:   cls = OPC_MEM;
        OP_BEQ, OP_BNE: cls = OPC_BRANCH;
        OP_J:           cls = OPC_JUMP;
        OP_HALT:        cls = OPC_HALT;
        default:        cls = OPC_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts consecutive cycles a memory access waits for ready and flags the
// timeout limit; TIMEOUT_CYCLES of 0 never expires.
module mc_mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             limit_s;

  // The current waiting cycle is the one that reaches the limit.
  assign limit_s = (32'(cnt_r) + 32'd1) >= TIMEOUT_CYCLES;
  assign expired = (TIMEOUT_CYCLES != 32'd0) && !ready && limit_s;

  // Wait counter: cleared on entry to a memory state, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (start) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!ready && !limit_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM of the multicycle CPU. Optional perf counters are enabled
// with the MC_PERF_CNT_EN macro.
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef MC_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] state_o,
  output logic       halted,
  output logic       fault
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  state_e    state_r;
  state_e    state_next_s;
  op_class_e op_class_s;
  logic      expired_s;
  logic      timer_start_s;

  assign op_class_s    = classify(Opcode);
  assign timer_start_s = (state_next_s != state_r);
  assign state_o       = state_r;

  mc_mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (timer_start_s),
    .ready  (mem_ready),
    .expired(expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and Moore output decode; only FETCH strobes follow mem_ready.
  always_comb begin
    state_next_s = state_r;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    BranchNe     = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_B;
    PCSource     = PCSRC_ALU;
    ALUOp        = ALUOP_ADD;
    halted       = 1'b0;
    fault        = 1'b0;
    case (state_r)
      ST_RESET: state_next_s = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          state_next_s = ST_DECODE;
        end else if (expired_s) begin
          state_next_s = ST_FAULT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (op_class_s)
          OPC_RTYPE, OPC_ITYPE: state_next_s = ST_EXEC;
          OPC_MEM:              state_next_s = ST_MEMADR;
          OPC_BRANCH:           state_next_s = ST_BRANCH;
          OPC_JUMP:             state_next_s = ST_JUMP;
          OPC_HALT:             state_next_s = ST_HALT;
          default:              state_next_s = ST_FAULT;
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (Opcode == OP_SW) begin
          state_next_s = ST_MEMWR;
        end else begin
          state_next_s = ST_MEMRD;
        end
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_next_s = ST_MEMWB;
        end else if (expired_s) begin
          state_next_s = ST_FAULT;
        end else begin
          state_next_s = ST_MEMRD;
        end
      end
      ST_MEMWB: begin
        RegWrite     = 1'b1;
        MemtoReg     = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_next_s = ST_FETCH;
        end else if (expired_s) begin
          state_next_s = ST_FAULT;
        end else begin
          state_next_s = ST_MEMWR;
        end
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        if (op_class_s == OPC_RTYPE) begin
          ALUOp   = ALUOP_RTYPE;
          ALUSrcB = SRCB_B;
        end else begin
          ALUOp   = ALUOP_IMM;
          ALUSrcB = SRCB_IMM;
        end
        state_next_s = ST_ALUWB;
      end
      ST_ALUWB: begin
        RegWrite     = 1'b1;
        RegDst       = (op_class_s == OPC_RTYPE);
        state_next_s = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOp        = ALUOP_BR;
        PCWriteCond  = 1'b1;
        PCSource     = PCSRC_ALUOUT;
        BranchNe     = Opcode[0];
        state_next_s = ST_FETCH;
      end
      ST_JUMP: begin
        PCWrite      = 1'b1;
        PCSource     = PCSRC_JUMP;
        state_next_s = ST_FETCH;
      end
      ST_HALT: begin
        halted       = 1'b1;
        state_next_s = ST_HALT;
      end
      ST_FAULT: begin
        fault        = 1'b1;
        state_next_s = ST_FAULT;
      end
      default: begin
        fault        = 1'b1;
        state_next_s = ST_FAULT;
      end
    endcase
  end

`ifdef MC_PERF_CNT_EN
  // Perf counters: active cycles, and completed instructions on return to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= {CNT_W{1'b0}};
      instr_cnt <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != ST_RESET) && (state_r != ST_HALT) && (state_r != ST_FAULT)) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end else begin
        cycle_cnt <= cycle_cnt;
      end
      if ((state_next_s == ST_FETCH) && (state_r != ST_FETCH) && (state_r != ST_RESET)) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end else begin
        instr_cnt <= instr_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: expected state and control vector per
// cycle are queued as stimulus is driven and compared half a cycle later.
module tb_mc_main_control;

  localparam logic [5:0] OP_R   = 6'b000010;
  localparam logic [5:0] OP_I   = 6'b001011;
  localparam logic [5:0] OP_LWC = 6'b010000;
  localparam logic [5:0] OP_SWC = 6'b010001;
  localparam logic [5:0] OP_BQ  = 6'b011000;
  localparam logic [5:0] OP_BN  = 6'b011001;
  localparam logic [5:0] OP_JC  = 6'b100000;
  localparam logic [5:0] OP_HL  = 6'b111111;
  localparam logic [5:0] OP_BAD = 6'b101010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, halted, fault;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       tag;
    int          st;
    logic [18:0] ctl;
  } exp_t;
  exp_t sb[$];

  logic [18:0] ctl_s;
  assign ctl_s = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
                  halted, fault};

  mc_main_control #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .state_o(state_o), .halted(halted),
    .fault(fault)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected controls for a state, written from the control table.
  function automatic logic [18:0] exp_ctl(input int st, input logic [5:0] op, input logic rdy);
    logic pcw = 1'b0, pcwc = 1'b0, bne = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0;
    logic irw = 1'b0, m2r = 1'b0, rdst = 1'b0, rw = 1'b0, sa = 1'b0, hlt = 1'b0, flt = 1'b0;
    logic [1:0] sb2 = 2'b00, pcs = 2'b00, aop = 2'b00;
    case (st)
      1: begin mrd = 1'b1; sb2 = 2'b01; irw = rdy; pcw = rdy; end
      2: sb2 = 2'b11;
      3: begin sa = 1'b1; sb2 = 2'b10; end
      4: begin mrd = 1'b1; iord = 1'b1; end
      5: begin rw = 1'b1; m2r = 1'b1; end
      6: begin mwr = 1'b1; iord = 1'b1; end
      7: begin
        sa = 1'b1;
        if (op[5:3] == 3'b000) begin aop = 2'b11; sb2 = 2'b00; end
        else begin aop = 2'b01; sb2 = 2'b10; end
      end
      8: begin rw = 1'b1; rdst = (op[5:3] == 3'b000); end
      9: begin sa = 1'b1; aop = 2'b10; pcwc = 1'b1; pcs = 2'b01; bne = op[0]; end
      10: begin pcw = 1'b1; pcs = 2'b10; end
      11: hlt = 1'b1;
      12: flt = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb2, pcs, aop, hlt, flt};
  endfunction

  // Drive one cycle's inputs, queue the expectation, compare after settling.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic rdy, input int st);
    exp_t e;
    @(negedge clk);
    rst_n     = rst;
    Opcode    = op;
    mem_ready = rdy;
    e.tag = tag;
    e.st  = st;
    e.ctl = exp_ctl(st, op, rdy);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/state"}, 32'(state_o), 32'(e.st));
    chk({e.tag, "/ctl"}, 32'(ctl_s), 32'(e.ctl));
  endtask

  initial begin
    rst_n = 1'b0; Opcode = 6'd0; mem_ready = 1'b0;
    step("reset", 1'b0, OP_R, 1'b1, 0);
    step("reset", 1'b0, OP_R, 1'b1, 0);
    step("release", 1'b1, OP_R, 1'b1, 0);
    // R-type
    step("r_fetch", 1'b1, OP_R, 1'b1, 1);
    step("r_dec", 1'b1, OP_R, 1'b1, 2);
    step("r_exec", 1'b1, OP_R, 1'b1, 7);
    step("r_wb", 1'b1, OP_R, 1'b1, 8);
    // Immediate with one FETCH stall
    step("i_fwait", 1'b1, OP_I, 1'b0, 1);
`ifdef MC_PERF_CNT_EN
    chk("instr_cnt", instr_cnt, 32'd1);
`endif
    step("i_fetch", 1'b1, OP_I, 1'b1, 1);
    step("i_dec", 1'b1, OP_I, 1'b1, 2);
    step("i_exec", 1'b1, OP_I, 1'b1, 7);
    step("i_wb", 1'b1, OP_I, 1'b1, 8);
    // LW with three wait cycles in MEMRD
    step("lw_fetch", 1'b1, OP_LWC, 1'b1, 1);
    step("lw_dec", 1'b1, OP_LWC, 1'b1, 2);
    step("lw_adr", 1'b1, OP_LWC, 1'b1, 3);
    for (int i = 0; i < 3; i++) step("lw_rdwait", 1'b1, OP_LWC, 1'b0, 4);
    step("lw_rd", 1'b1, OP_LWC, 1'b1, 4);
    step("lw_wb", 1'b1, OP_LWC, 1'b1, 5);
    // SW with one wait cycle
    step("sw_fetch", 1'b1, OP_SWC, 1'b1, 1);
    step("sw_dec", 1'b1, OP_SWC, 1'b1, 2);
    step("sw_adr", 1'b1, OP_SWC, 1'b1, 3);
    step("sw_wait", 1'b1, OP_SWC, 1'b0, 6);
    step("sw_wr", 1'b1, OP_SWC, 1'b1, 6);
    // Branches and jump
    step("bne_fetch", 1'b1, OP_BN, 1'b1, 1);
    step("bne_dec", 1'b1, OP_BN, 1'b1, 2);
    step("bne_br", 1'b1, OP_BN, 1'b1, 9);
    step("beq_fetch", 1'b1, OP_BQ, 1'b1, 1);
    step("beq_dec", 1'b1, OP_BQ, 1'b1, 2);
    step("beq_br", 1'b1, OP_BQ, 1'b1, 9);
    step("j_fetch", 1'b1, OP_JC, 1'b1, 1);
    step("j_dec", 1'b1, OP_JC, 1'b1, 2);
    step("j_jump", 1'b1, OP_JC, 1'b1, 10);
    // FETCH timeout after four waiting cycles
    for (int i = 0; i < 4; i++) step("to_wait", 1'b1, OP_R, 1'b0, 1);
    step("to_fault", 1'b1, OP_R, 1'b0, 12);
    step("to_hold", 1'b1, OP_R, 1'b1, 12);
    // HALT is terminal
    step("h_reset", 1'b0, OP_HL, 1'b1, 0);
    step("h_release", 1'b1, OP_HL, 1'b1, 0);
    step("h_fetch", 1'b1, OP_HL, 1'b1, 1);
    step("h_dec", 1'b1, OP_HL, 1'b1, 2);
    for (int i = 0; i < 100; i++) step("h_hold", 1'b1, OP_HL, 1'($urandom_range(0, 1)), 11);
    // Illegal opcode
    step("il_reset", 1'b0, OP_BAD, 1'b1, 0);
    step("il_release", 1'b1, OP_BAD, 1'b1, 0);
    step("il_fetch", 1'b1, OP_BAD, 1'b1, 1);
    step("il_dec", 1'b1, OP_BAD, 1'b1, 2);
    step("il_fault", 1'b1, OP_BAD, 1'b1, 12);
    // Reset during a MEMWR wait aborts the write
    step("ab_reset", 1'b0, OP_SWC, 1'b1, 0);
    step("ab_release", 1'b1, OP_SWC, 1'b1, 0);
    step("ab_fetch", 1'b1, OP_SWC, 1'b1, 1);
    step("ab_dec", 1'b1, OP_SWC, 1'b1, 2);
    step("ab_adr", 1'b1, OP_SWC, 1'b1, 3);
    step("ab_wait", 1'b1, OP_SWC, 1'b0, 6);
    step("ab_wait", 1'b1, OP_SWC, 1'b0, 6);
    step("ab_abort", 1'b0, OP_SWC, 1'b0, 0);
    step("ab_release", 1'b1, OP_SWC, 1'b0, 0);
    step("ab_post", 1'b1, OP_R, 1'b1, 1);
    step("ab_post", 1'b1, OP_R, 1'b1, 2);
    step("ab_post", 1'b1, OP_R, 1'b1, 7);
    step("ab_post", 1'b1, OP_R, 1'b1, 8);
    step("ab_post", 1'b1, OP_R, 1'b1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
